signed_or_unsigned_mul_seq: RTL and testbench

- Iterative, parameterised multiplier: processes one multiplier bit per clock and produces a 2n-bit product.
- Signedness is selected per operand, per transaction, so the block covers unsigned×unsigned, signed×signed and mixed signed×unsigned (MULHSU-style).
- Uses valid/ready handshakes on input and output.
- Area-cheap replacement for the combinational multiplier in datapaths that can tolerate multi-cycle latency.

---
 rtl/signed_or_unsigned_mul_seq.sv | 139 +++++++++++++
 tb/tb_signed_or_unsigned_mul_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_or_unsigned_mul_seq.sv
// Iterative shift-add multiplier with per-operand signedness select.
// One bit of the multiplier b is consumed per clock, LSB first. The last
// bit carries negative weight when b is two's complement, so the same
// datapath covers unsigned, signed and mixed-sign products. Results are
// taken modulo 2^(2n), which makes every mode combination exact.
module signed_or_unsigned_mul_seq #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [2*n-1:0]   res
);

    localparam int W2 = 2 * n;
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r, state_nx_s;
    logic [W2-1:0]   a_sh_r, a_sh_nx_s;     // extended multiplicand, pre-shifted by bit index
    logic [n-1:0]    b_sh_r, b_sh_nx_s;     // remaining multiplier bits, current bit at [0]
    logic            b_signed_r, b_signed_nx_s;
    logic [W2-1:0]   acc_r, acc_nx_s;
    logic [CW-1:0]   cnt_r, cnt_nx_s;
    logic [W2-1:0]   res_r, res_nx_s;
    logic            up_ready_r, up_ready_nx_s;
    logic            down_valid_r, down_valid_nx_s;

    logic [W2-1:0]   ext_a_s;
    logic [W2-1:0]   partial_s;
    logic            last_bit_s;

    // Operand extension and the partial product selected by the current multiplier bit.
    always_comb begin
        ext_a_s    = {{n{a_signed & a[n-1]}}, a};
        last_bit_s = (cnt_r == CW'(n - 1));
        if (b_sh_r[0]) begin
            partial_s = a_sh_r;
        end else begin
            partial_s = {W2{1'b0}};
        end
    end

    // Next-state and datapath update; all targets hold by default.
    always_comb begin
        state_nx_s    = state_r;
        a_sh_nx_s     = a_sh_r;
        b_sh_nx_s     = b_sh_r;
        b_signed_nx_s = b_signed_r;
        acc_nx_s      = acc_r;
        cnt_nx_s      = cnt_r;
        res_nx_s      = res_r;
        case (state_r)
            IDLE: begin
                if (up_valid) begin
                    a_sh_nx_s     = ext_a_s;
                    b_sh_nx_s     = b;
                    b_signed_nx_s = b_signed;
                    acc_nx_s      = {W2{1'b0}};
                    cnt_nx_s      = {CW{1'b0}};
                    state_nx_s    = BUSY;
                end else begin
                    state_nx_s    = IDLE;
                end
            end
            BUSY: begin
                if (last_bit_s) begin
                    // MSB of a signed multiplier weighs -2^(n-1).
                    if (b_signed_r) begin
                        acc_nx_s = acc_r - partial_s;
                    end else begin
                        acc_nx_s = acc_r + partial_s;
                    end
                    res_nx_s   = acc_nx_s;
                    state_nx_s = DONE;
                end else begin
                    acc_nx_s  = acc_r + partial_s;
                    a_sh_nx_s = {a_sh_r[W2-2:0], 1'b0};
                    b_sh_nx_s = {1'b0, b_sh_r[n-1:1]};
                    cnt_nx_s  = cnt_r + CW'(1);
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        up_ready_nx_s   = (state_nx_s == IDLE);
        down_valid_nx_s = (state_nx_s == DONE);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            a_sh_r       <= {W2{1'b0}};
            b_sh_r       <= {n{1'b0}};
            b_signed_r   <= 1'b0;
            acc_r        <= {W2{1'b0}};
            cnt_r        <= {CW{1'b0}};
            res_r        <= {W2{1'b0}};
            up_ready_r   <= 1'b1;
            down_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            a_sh_r       <= a_sh_nx_s;
            b_sh_r       <= b_sh_nx_s;
            b_signed_r   <= b_signed_nx_s;
            acc_r        <= acc_nx_s;
            cnt_r        <= cnt_nx_s;
            res_r        <= res_nx_s;
            up_ready_r   <= up_ready_nx_s;
            down_valid_r <= down_valid_nx_s;
        end
    end

    assign up_ready   = up_ready_r;
    assign down_valid = down_valid_r;
    assign res        = res_r;

endmodule

// File: tb/tb_signed_or_unsigned_mul_seq.sv
// Self-checking bench for signed_or_unsigned_mul_seq: directed n=8 vectors,
// backpressure and mid-operation reset sequences, and randomised runs at
// n=4 and n=16 against a reference product model.
module tb_signed_or_unsigned_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // n = 8 instance
    logic        uv8, ur8, as8, bs8, dv8, dr8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;
    // n = 4 instance
    logic        uv4, ur4, as4, bs4, dv4, dr4;
    logic [3:0]  a4, b4;
    logic [7:0]  r4;
    // n = 16 instance
    logic        uv16, ur16, as16, bs16, dv16, dr16;
    logic [15:0] a16, b16;
    logic [31:0] r16;

    signed_or_unsigned_mul_seq #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .up_valid(uv8), .up_ready(ur8), .a(a8), .b(b8),
        .a_signed(as8), .b_signed(bs8), .down_valid(dv8), .down_ready(dr8), .res(r8));
    signed_or_unsigned_mul_seq #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .up_valid(uv4), .up_ready(ur4), .a(a4), .b(b4),
        .a_signed(as4), .b_signed(bs4), .down_valid(dv4), .down_ready(dr4), .res(r4));
    signed_or_unsigned_mul_seq #(.n(16)) dut16 (
        .clk(clk), .rst(rst), .up_valid(uv16), .up_ready(ur16), .a(a16), .b(b16),
        .a_signed(as16), .b_signed(bs16), .down_valid(dv16), .down_ready(dr16), .res(r16));

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sa;
        logic        sb;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: interpret operands per flag, multiply, keep low 2w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input logic sx, input logic sy);
        longint vx, vy, p;
        vx = longint'(x);
        vy = longint'(y);
        if (sx && x[w-1]) vx = vx - (longint'(1) << w);
        if (sy && y[w-1]) vy = vy - (longint'(1) << w);
        p = vx * vy;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One complete n=8 transaction; called at #1 after a rising edge with the DUT idle.
    task automatic do_op8(input logic [7:0] xa, input logic [7:0] xb, input logic sa, input logic sb,
                          input logic [15:0] exp, input string nm);
        int lat;
        logic ur_bad;
        check({nm, "_up_ready_idle"}, {63'd0, ur8}, 64'd1);
        a8 = xa; b8 = xb; as8 = sa; bs8 = sb; uv8 = 1'b1;
        @(posedge clk); #1;
        uv8 = 1'b0;
        a8 = ~xa; b8 = ~xb;   // must not disturb the captured operands
        lat = 0;
        ur_bad = 1'b0;
        while (!dv8 && lat < 40) begin
            if (ur8) ur_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (ur8) ur_bad = 1'b1;
        check({nm, "_latency"}, 64'(lat), 64'd8);
        check({nm, "_res"}, {48'd0, r8}, {48'd0, exp});
        check({nm, "_up_ready_busy"}, {63'd0, ur_bad}, 64'd0);
        dr8 = 1'b1;
        @(posedge clk); #1;
        dr8 = 1'b0;
        check({nm, "_ready_after"}, {62'd0, ur8, dv8}, 64'd2);
    endtask

    // Randomised n=4 transactions with stalls and input churn.
    task automatic rand4(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int guard;
            logic [63:0] exp;
            a4 = 4'($urandom); b4 = 4'($urandom); as4 = 1'($urandom); bs4 = 1'($urandom);
            exp = ref_mul(4, {60'd0, a4}, {60'd0, b4}, as4, bs4);
            guard = 0;
            while (!ur4 && guard < 50) begin @(posedge clk); #1; guard++; end
            uv4 = 1'b1;
            @(posedge clk); #1;
            guard = 0;
            while (!dv4 && guard < 50) begin
                uv4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
                dr4 = 1'($urandom);
                @(posedge clk); #1;
                guard++;
            end
            uv4 = 1'b0; dr4 = 1'b0;
            check("rand4_res", {55'd0, dv4, r4}, {55'd0, 1'b1, exp[7:0]});
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            dr4 = 1'b1;
            @(posedge clk); #1;
            dr4 = 1'b0;
        end
    endtask

    // Randomised n=16 transactions with stalls and input churn.
    task automatic rand16(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int guard;
            logic [63:0] exp;
            a16 = 16'($urandom); b16 = 16'($urandom); as16 = 1'($urandom); bs16 = 1'($urandom);
            exp = ref_mul(16, {48'd0, a16}, {48'd0, b16}, as16, bs16);
            guard = 0;
            while (!ur16 && guard < 50) begin @(posedge clk); #1; guard++; end
            uv16 = 1'b1;
            @(posedge clk); #1;
            guard = 0;
            while (!dv16 && guard < 50) begin
                uv16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
                dr16 = 1'($urandom);
                @(posedge clk); #1;
                guard++;
            end
            uv16 = 1'b0; dr16 = 1'b0;
            check("rand16_res", {31'd0, dv16, r16}, {31'd0, 1'b1, exp[31:0]});
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            dr16 = 1'b1;
            @(posedge clk); #1;
            dr16 = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0001};
        vecs[3]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 16'hC080};
        vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFF01};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01};
        vecs[6]  = '{8'h03, 8'h05, 1'b0, 1'b0, 16'h000F};
        vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01};
        vecs[8]  = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080};
        vecs[9]  = '{8'h80, 8'hFF, 1'b1, 1'b0, 16'h8080};
        vecs[10] = '{8'h80, 8'hFF, 1'b0, 1'b1, 16'hFF80};
        vecs[11] = '{8'h00, 8'hA5, 1'b1, 1'b1, 16'h0000};

        rst = 1'b1;
        uv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; as8 = 1'b0; bs8 = 1'b0; dr8 = 1'b0;
        uv4 = 1'b0; a4 = 4'd0; b4 = 4'd0; as4 = 1'b0; bs4 = 1'b0; dr4 = 1'b0;
        uv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; as16 = 1'b0; bs16 = 1'b0; dr16 = 1'b0;
        #12;
        check("reset_outputs", {46'd0, ur8, dv8, r8}, {46'd0, 1'b1, 1'b0, 16'h0000});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op8(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result, try to push a new operation meanwhile.
        begin
            int guard;
            a8 = 8'h12; b8 = 8'h34; as8 = 1'b0; bs8 = 1'b0; uv8 = 1'b1;
            @(posedge clk); #1;
            uv8 = 1'b0;
            guard = 0;
            while (!dv8 && guard < 40) begin @(posedge clk); #1; guard++; end
            for (int k = 0; k < 5; k++) begin
                uv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
                @(posedge clk); #1;
                check("bp_hold", {46'd0, ur8, dv8, r8}, {46'd0, 1'b0, 1'b1, 16'h03A8});
            end
            uv8 = 1'b0;
            dr8 = 1'b1;
            @(posedge clk); #1;
            dr8 = 1'b0;
            check("bp_release", {62'd0, ur8, dv8}, 64'd2);
            @(posedge clk); #1;
            check("bp_idle_stays", {62'd0, ur8, dv8}, 64'd2);
        end

        // Reset in the middle of an operation, between clock edges.
        a8 = 8'h3C; b8 = 8'h5A; as8 = 1'b0; bs8 = 1'b0; uv8 = 1'b1;
        @(posedge clk); #1;
        uv8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {46'd0, ur8, dv8, r8}, {46'd0, 1'b1, 1'b0, 16'h0000});
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_discards", {62'd0, ur8, dv8}, 64'd2);
        do_op8(8'h03, 8'h05, 1'b0, 1'b0, 16'h000F, "post_reset");

        rand4(300);
        rand16(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
